// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control path: word width, ALU opcode class
// and the instruction sequencer state encoding.
package cpu_ctrl_pkg;

    localparam int unsigned WORD_W = 16;

    // Instructions whose top two bits equal this code run on the ALU
    localparam logic [1:0] CODE_ALU = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_EXT    = 3'd4
    } seq_state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of every sequencer-facing signal: instruction memory, ALU flag
// interface, external-unit handshake and run/status.
//   master : the sequencer (drives imem_*, instr, exec1, flags, ext_start, status)
//   slave  : the environment (memory, ALU, external unit, run control)
interface alu_sequencer_if;
    import cpu_ctrl_pkg::*;

    logic              run;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_req;
    logic              imem_ack;
    logic [WORD_W-1:0] imem_rdata;
    logic [WORD_W-1:0] instr;
    logic              exec1;
    logic              carry_q;
    logic              skip_q;
    logic              carry_d;
    logic              carry_en;
    logic              skip_d;
    logic              skip_en;
    logic              ext_start;
    logic              ext_done;
    logic              pc_load;
    logic [WORD_W-1:0] pc_load_val;
    logic              busy;
    logic [WORD_W-1:0] retired;

    modport master (
        input  run, imem_ack, imem_rdata, carry_d, carry_en, skip_d, skip_en,
               ext_done, pc_load, pc_load_val,
        output imem_addr, imem_req, instr, exec1, carry_q, skip_q, ext_start,
               busy, retired
    );

    modport slave (
        output run, imem_ack, imem_rdata, carry_d, carry_en, skip_d, skip_en,
               ext_done, pc_load, pc_load_val,
        input  imem_addr, imem_req, instr, exec1, carry_q, skip_q, ext_start,
               busy, retired
    );

endinterface

// File: rtl/ctrl_flags.sv
// CARRY and SKIP flip-flops read and updated by the ALU.
//   clk, rst_n   : clock, async active-low reset (both flags reset to 0)
//   i_exec       : high during the EXEC cycle; only then do ALU enables apply
//   i_skip_clr   : consume a pending skip (DECODE of a skipped instruction)
//   i_carry_d/en : ALU carry next value / enable
//   i_skip_d/en  : ALU skip next value / enable
//   o_carry_q    : CARRY flag
//   o_skip_q     : SKIP flag
module ctrl_flags (
    input  logic clk,
    input  logic rst_n,
    input  logic i_exec,
    input  logic i_skip_clr,
    input  logic i_carry_d,
    input  logic i_carry_en,
    input  logic i_skip_d,
    input  logic i_skip_en,
    output logic o_carry_q,
    output logic o_skip_q
);

    logic r_carry;
    logic r_skip;

    // CARRY: ALU update during EXEC only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
        end else if (i_exec && i_carry_en) begin
            r_carry <= i_carry_d;
        end
    end

    // SKIP: ALU update during EXEC, cleared when a skip is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skip <= 1'b0;
        end else if (i_exec && i_skip_en) begin
            r_skip <= i_skip_d;
        end else if (i_skip_clr) begin
            r_skip <= 1'b0;
        end
    end

    assign o_carry_q = r_carry;
    assign o_skip_q  = r_skip;

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer: fetches into IR', strobes the ALU (exec1) for
// class-11 instructions, hands other instructions to an external unit via
// ext_start/ext_done, and counts retired instructions.
//   PC_RESET : PC value after reset
//   clk      : system clock
//   rst_n    : async active-low reset
//   bus      : alu_sequencer_if.master (memory, ALU, external unit, status)
module alu_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter logic [WORD_W-1:0] PC_RESET = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_sequencer_if.master   bus
);

    seq_state_t        r_state;
    seq_state_t        w_state_nx;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] w_pc_nx;
    logic [WORD_W-1:0] r_ir;
    logic [WORD_W-1:0] w_ir_nx;
    logic [WORD_W-1:0] r_retired;
    logic [WORD_W-1:0] w_retired_nx;
    logic              w_ext_start_nx;
    logic              w_skip_clr;
    logic              w_exec;
    logic              w_carry_q;
    logic              w_skip_q;

    logic              r_imem_req;
    logic              r_exec1;
    logic              r_ext_start;
    logic              r_busy;

    assign w_exec = (r_state == ST_EXEC);

    ctrl_flags u_flags (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_exec     (w_exec),
        .i_skip_clr (w_skip_clr),
        .i_carry_d  (bus.carry_d),
        .i_carry_en (bus.carry_en),
        .i_skip_d   (bus.skip_d),
        .i_skip_en  (bus.skip_en),
        .o_carry_q  (w_carry_q),
        .o_skip_q   (w_skip_q)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state, datapath next values and output decode
    always_comb begin
        w_state_nx     = r_state;
        w_pc_nx        = r_pc;
        w_ir_nx        = r_ir;
        w_retired_nx   = r_retired;
        w_ext_start_nx = 1'b0;
        w_skip_clr     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.run) begin
                    w_state_nx = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    w_ir_nx    = bus.imem_rdata;
                    w_pc_nx    = r_pc + WORD_W'(1);
                    w_state_nx = ST_DECODE;
                    // SKIP cannot change during FETCH, so the DECODE outcome
                    // is known here and ext_start can be registered for it.
                    w_ext_start_nx = !w_skip_q &&
                                     (bus.imem_rdata[15:14] != CODE_ALU);
                end
            end
            ST_DECODE: begin
                if (w_skip_q) begin
                    w_skip_clr = 1'b1;
                    w_state_nx = bus.run ? ST_FETCH : ST_IDLE;
                end else if (r_ir[15:14] == CODE_ALU) begin
                    w_state_nx = ST_EXEC;
                end else begin
                    w_state_nx = ST_EXT;
                end
            end
            ST_EXEC: begin
                w_retired_nx = r_retired + WORD_W'(1);
                w_state_nx   = bus.run ? ST_FETCH : ST_IDLE;
            end
            ST_EXT: begin
                if (bus.ext_done) begin
                    if (bus.pc_load) begin
                        w_pc_nx = bus.pc_load_val;
                    end
                    w_retired_nx = r_retired + WORD_W'(1);
                    w_state_nx   = bus.run ? ST_FETCH : ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // PC, IR' and retired counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= PC_RESET;
            r_ir      <= '0;
            r_retired <= '0;
        end else begin
            r_pc      <= w_pc_nx;
            r_ir      <= w_ir_nx;
            r_retired <= w_retired_nx;
        end
    end

    // Strobes are registered decodes of the next state, so each is high for
    // exactly the cycles spent in the corresponding state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imem_req  <= 1'b0;
            r_exec1     <= 1'b0;
            r_ext_start <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_imem_req  <= (w_state_nx == ST_FETCH);
            r_exec1     <= (w_state_nx == ST_EXEC);
            r_ext_start <= w_ext_start_nx;
            r_busy      <= (w_state_nx != ST_IDLE);
        end
    end

    assign bus.imem_addr = r_pc;
    assign bus.imem_req  = r_imem_req;
    assign bus.instr     = r_ir;
    assign bus.exec1     = r_exec1;
    assign bus.carry_q   = w_carry_q;
    assign bus.skip_q    = w_skip_q;
    assign bus.ext_start = r_ext_start;
    assign bus.busy      = r_busy;
    assign bus.retired   = r_retired;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Instruction-level sequencer for the 16-bit CPU core. It fetches instructions from instruction memory and holds them in IR'. It generates the single-cycle `exec1` strobe for the ALU and owns the CARRY and SKIP flip-flops the ALU reads and updates. Instructions whose top two bits are not `11` are handed to an external unit through a start/done handshake. The block sits between instruction memory, the ALU and the register-file write port.

## Interface
- `PC_RESET`, default 16'h0000: PC value loaded on reset.
- `clk` in 1: single system clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `run` in 1: 1 = execute instructions; 0 = stop at the next instruction boundary.
- `imem_addr` out 16: current PC.
- `imem_req` out 1: fetch request.
- `imem_ack` in 1: fetch complete; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 16: fetched instruction word.
- `instr` out 16: IR' contents, to the ALU `instruction` input.
- `exec1` out 1: ALU execute strobe, one cycle wide.
- `carry_q` out 1: CARRY flip-flop, to ALU `carrystatus`.
- `skip_q` out 1: SKIP flip-flop, to ALU `skipstatus`.
- `carry_d`, `carry_en` in 1 each: CARRY next value and enable, from the ALU.
- `skip_d`, `skip_en` in 1 each: SKIP next value and enable, from the ALU.
- `ext_start` out 1: one-cycle start pulse for a non-ALU instruction.
- `ext_done` in 1: external unit has finished.
- `pc_load` in 1, `pc_load_val` in 16: PC overwrite (jump), sampled only together with `ext_done`.
- `busy` out 1: 1 in any state other than IDLE.
- `retired` out 16: count of executed (not skipped) instructions; wraps at 16'hFFFF → 0.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, EXT.
- **IDLE**: if `run`=1, go to FETCH.
- **FETCH**: `imem_req`=1. On `imem_ack`=1: IR' ← `imem_rdata`, PC ← PC+1 (wraps 16'hFFFF → 0), go to DECODE. Without ack, stay; `imem_req` stays high.
- **DECODE**:
  - If `skip_q`=1: clear SKIP, do not execute, do not count. Go to FETCH, or IDLE if `run`=0. A skip applies to any instruction type.
  - Else if `instr[15:14]`=2'b11: go to EXEC.
  - Else: pulse `ext_start`, go to EXT.
- **EXEC**: `exec1`=1 for exactly this cycle.
  - At the closing edge: CARRY ← `carry_d` if `carry_en`; SKIP ← `skip_d` if `skip_en`.
  - `retired` increments.
  - Next state: FETCH if `run`=1, else IDLE.
- **EXT**: wait for `ext_done`=1.
  - On that cycle: if `pc_load`=1, PC ← `pc_load_val`. `retired` increments.
  - Next state: FETCH or IDLE, decided by `run` as in EXEC.
  - `pc_load` without `ext_done`, or in any other state, is ignored.
- **`run` deassertion**: never aborts FETCH, EXEC or EXT. It is sampled only at instruction completion and in IDLE.
- **Flags**: change only in EXEC (ALU enables) or DECODE (skip clear). `carry_en`/`skip_en` outside EXEC are ignored.
- **Reset**:
  - PC=`PC_RESET`, IR'=0, CARRY=0, SKIP=0, `retired`=0, state IDLE.
  - All outputs 0, except `imem_addr`=`PC_RESET` and `instr`=0.
  - Reset asserted mid-instruction abandons it immediately; flags are not updated.

## Timing
- ALU instruction with `imem_ack` in the first FETCH cycle takes 3 cycles: FETCH, DECODE, EXEC. Each fetch wait cycle adds 1.
- Skipped instruction: 2 cycles (FETCH, DECODE).
- External instruction: 2 + n cycles, where n ≥ 1 is the number of EXT cycles up to and including `ext_done`.
- Flags updated in EXEC are visible on `carry_q`/`skip_q` in the following FETCH cycle. The very next DECODE therefore sees a SKIP set by the preceding instruction.
- `exec1` and `ext_start` are never high in the same cycle.
- `exec1` is never high outside EXEC.
- `instr` is stable from DECODE through the end of EXEC/EXT.
- `exec1` is a registered decode of state: high for the whole EXEC cycle, glitch-free.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - state enum `seq_state_t`
  - `CODE_ALU` = 2'b11
  - `WORD_W` = 16
- Sub-module `ctrl_flags` holds CARRY/SKIP with their enable, clear and reset logic. The top level holds the FSM, PC, IR' and `retired`.

## Test plan
- **Reset**: `rst_n`=0 mid-EXEC → `exec1`=0, `carry_q`=0, `skip_q`=0, `imem_addr`=16'h0000 asynchronously; after release with `run`=0, stays IDLE and `busy`=0.
- **Zero-wait ALU stream**: `run`=1, `imem_ack` always 1, memory returns 16'hC000 → `exec1` pulses every 3rd cycle; PC 0,1,2…; `retired`=3 after 9 cycles.
- **Carry update**: ALU drives `carry_en`=1, `carry_d`=1 during EXEC → `carry_q`=1 from the next cycle; `carry_en`=1 asserted in FETCH → no change.
- **Skip**: SKIP set in EXEC of the instruction at address 4 → instruction 5 is fetched but gets no `exec1` and `retired` does not count it; `skip_q`=0 after DECODE; instruction 6 executes.
- **External jump**: word 16'h4000 → `ext_start` for 1 cycle; `ext_done`+`pc_load` with 16'h0100 on the 3rd EXT cycle → next `imem_addr`=16'h0100.
- **Wait states and stop**: `imem_ack` delayed 4 cycles with `run` dropped during FETCH → `imem_req` held 5 cycles, the instruction executes, then IDLE; PC wrap from 16'hFFFF gives `imem_addr`=0.
